// File: rtl/sram_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sram_ctrl_pkg
// Shared definitions for the burst SRAM controller:
//   state_e    - controller FSM states
//   SRAM_DW    - SRAM data width (halfword)
//   WR_BEATS   - halfword beats per 32-bit write
//   cnt_width  - width of a counter that must hold 0..n-1 (at least 1 bit)
// -----------------------------------------------------------------------------
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int SRAM_DW  = 16;
  localparam int WR_BEATS = 2;

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sram_wait_timer.sv
// -----------------------------------------------------------------------------
// sram_wait_timer
// Beat timer: while run is high, each beat lasts WAIT+1 cycles. beat_last is
// high on the final cycle of a beat. The count returns to 0 after the last
// cycle and is held at 0 while run is low, so every beat starts from 0.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   run        - a beat is in progress
//   beat_last  - current cycle is the last cycle of the beat
// -----------------------------------------------------------------------------
module sram_wait_timer
  import sram_ctrl_pkg::*;
#(
  parameter int WAIT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic beat_last
);

  localparam int CW = cnt_width(WAIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WAIT);

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (!run || cnt_reg == CNT_MAX) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt_reg + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign beat_last = run && (cnt_reg == CNT_MAX);

endmodule

// File: rtl/sram_burst_ctrl.sv
// -----------------------------------------------------------------------------
// sram_burst_ctrl
// Bridges a 32-bit request port to an asynchronous 16-bit SRAM. Reads fetch an
// aligned line of BURST halfwords; writes store one 32-bit word as two
// halfword beats. Each beat lasts WAIT+1 cycles. A DONE cycle with rsp_valid
// closes every completed request.
// Optional feature: define SRAM_CTRL_BYTE_MASK_EN to add req_be[3:0] and
// drive SRAM_UB_N / SRAM_LB_N from the byte enables during writes.
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   req_valid/req_ready  - request handshake (ready only in IDLE)
//   req_we               - 1 = write, 0 = read
//   req_addr, req_wdata  - byte address, write word
//   req_be               - byte enables (only with SRAM_CTRL_BYTE_MASK_EN)
//   rsp_valid            - one-cycle completion pulse
//   rsp_rdata            - last read line, halfword i at [16i+15:16i]
//   busy                 - pipeline freeze request
//   SRAM_*               - SRAM pins (CE_N tied active)
// -----------------------------------------------------------------------------
module sram_burst_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int BURST   = 4,
  parameter int WAIT    = 0,
  parameter int SRAM_AW = 18
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [31:0]              req_addr,
  input  logic [31:0]              req_wdata,
`ifdef SRAM_CTRL_BYTE_MASK_EN
  input  logic [3:0]               req_be,
`endif
  output logic                     rsp_valid,
  output logic [SRAM_DW*BURST-1:0] rsp_rdata,
  output logic                     busy,
  inout  wire  [SRAM_DW-1:0]       SRAM_DQ,
  output logic [SRAM_AW-1:0]       SRAM_ADDR,
  output logic                     SRAM_WE_N,
  output logic                     SRAM_OE_N,
  output logic                     SRAM_CE_N,
  output logic                     SRAM_UB_N,
  output logic                     SRAM_LB_N
);

  localparam int BEAT_W   = cnt_width(BURST);
  // Byte-address bit where the read line index starts (line = 2*BURST bytes).
  localparam int LINE_LSB = BEAT_W + 1;
  localparam logic [BEAT_W-1:0] RD_LAST = BEAT_W'(BURST - 1);
  localparam logic [BEAT_W-1:0] WR_LAST = BEAT_W'(WR_BEATS - 1);

  state_e              state_reg;
  state_e              state_next;
  logic [BEAT_W-1:0]   beat_reg;
  logic [BEAT_W-1:0]   beat_next;
  logic [SRAM_AW:2]    addr_reg;
  logic [SRAM_AW:2]    addr_src;
  logic [31:0]         wdata_reg;
  logic [SRAM_AW-1:0]  sram_addr_reg;
  logic [SRAM_AW-1:0]  sram_addr_next;
  logic                load;
  logic                in_write;
  logic                in_beat;
  logic                beat_last;
  logic                capture;
  logic [SRAM_DW-1:0]  wr_half;
  wire  [SRAM_DW*BURST-1:0] rdata_line;

  // Only halfword/word address bits inside the SRAM are meaningful.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[31:SRAM_AW+1], req_addr[1:0]};

  assign in_write = (state_reg == WRITE);
  assign in_beat  = (state_reg == READ) || in_write;

  sram_wait_timer #(
    .WAIT (WAIT)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .run       (in_beat),
    .beat_last (beat_last)
  );

  // Next state, beat index and the SRAM address for the coming cycle.
  // The address is registered so it stays put between requests.
  always_comb begin
    state_next     = state_reg;
    beat_next      = beat_reg;
    load           = 1'b0;
    addr_src       = addr_reg;
    sram_addr_next = sram_addr_reg;

    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          load       = 1'b1;
          beat_next  = '0;
          state_next = req_we ? WRITE : READ;
        end
      end
      READ: begin
        if (beat_last) begin
          if (beat_reg == RD_LAST) begin
            state_next = DONE;
          end else begin
            beat_next = beat_reg + BEAT_W'(1);
          end
        end
      end
      WRITE: begin
        if (beat_last) begin
          if (beat_reg == WR_LAST) begin
            state_next = DONE;
          end else begin
            beat_next = beat_reg + BEAT_W'(1);
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (load) begin
      addr_src = req_addr[SRAM_AW:2];
    end

    if (state_next == WRITE) begin
      sram_addr_next = {addr_src[SRAM_AW:2], beat_next[0]};
    end else if (state_next == READ) begin
      sram_addr_next = {addr_src[SRAM_AW:LINE_LSB], beat_next};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      beat_reg      <= '0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      sram_addr_reg <= '0;
    end else begin
      state_reg     <= state_next;
      beat_reg      <= beat_next;
      sram_addr_reg <= sram_addr_next;
      if (load) begin
        addr_reg  <= req_addr[SRAM_AW:2];
        wdata_reg <= req_wdata;
      end
    end
  end

  // Read capture: each halfword slot has its own register so a line fills
  // in place and holds until the next read overwrites it.
  assign capture = (state_reg == READ) && beat_last;

  genvar gi;
  generate
    for (gi = 0; gi < BURST; gi++) begin : g_hw
      logic [SRAM_DW-1:0] hw_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          hw_reg <= '0;
        end else if (capture && beat_reg == BEAT_W'(gi)) begin
          hw_reg <= SRAM_DQ;
        end
      end
      assign rdata_line[gi*SRAM_DW +: SRAM_DW] = hw_reg;
    end
  endgenerate

  assign rsp_rdata = rdata_line;

  // Write data: beat 0 carries the low halfword, beat 1 the high one.
  assign wr_half = beat_reg[0] ? wdata_reg[31:16] : wdata_reg[15:0];
  assign SRAM_DQ = in_write ? wr_half : {SRAM_DW{1'bz}};

  assign req_ready = (state_reg == IDLE);
  assign rsp_valid = (state_reg == DONE);
  assign busy      = (state_reg == IDLE) ? req_valid : (state_reg != DONE);
  assign SRAM_ADDR = sram_addr_reg;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = in_write;

`ifdef SRAM_CTRL_BYTE_MASK_EN
  logic [3:0] be_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      be_reg <= '0;
    end else if (load) begin
      be_reg <= req_be;
    end
  end

  // An all-zero mask still walks the write beats but never strobes WE_N.
  assign SRAM_WE_N = ~(in_write && (|be_reg));
  assign SRAM_LB_N = in_write ? ~be_reg[{beat_reg[0], 1'b0}] : 1'b0;
  assign SRAM_UB_N = in_write ? ~be_reg[{beat_reg[0], 1'b1}] : 1'b0;
`else
  assign SRAM_WE_N = ~in_write;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
`endif

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_burst_ctrl
// Directed bench for sram_burst_ctrl: WAIT=0 instance with a read/write SRAM
// model, plus a WAIT=2 instance sharing the same memory for reads.
// -----------------------------------------------------------------------------
module tb_sram_burst_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // WAIT=0 instance
  logic        req_valid, req_we, req_ready, rsp_valid, busy;
  logic [31:0] req_addr, req_wdata;
  logic [63:0] rsp_rdata;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        we_n, oe_n, ce_n, ub_n, lb_n;
`ifdef SRAM_CTRL_BYTE_MASK_EN
  logic [3:0]  req_be;
`endif

  // WAIT=2 instance
  logic        req_valid2, req_we2, req_ready2, rsp_valid2, busy2;
  logic [31:0] req_addr2, req_wdata2;
  logic [63:0] rsp_rdata2;
  wire  [15:0] sram_dq2;
  logic [17:0] sram_addr2;
  logic        we_n2, oe_n2, ce_n2, ub_n2, lb_n2;

  int n_cmp = 0;
  int n_err = 0;
  int contention = 0;
  int we_low_cnt = 0;

  logic [15:0] mem [1024];
  logic        model_en;

  sram_burst_ctrl #(.BURST(4), .WAIT(0), .SRAM_AW(18)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef SRAM_CTRL_BYTE_MASK_EN
    .req_be(req_be),
`endif
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr), .SRAM_WE_N(we_n),
    .SRAM_OE_N(oe_n), .SRAM_CE_N(ce_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
  );

  sram_burst_ctrl #(.BURST(4), .WAIT(2), .SRAM_AW(18)) dut2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid2), .req_ready(req_ready2), .req_we(req_we2),
    .req_addr(req_addr2), .req_wdata(req_wdata2),
`ifdef SRAM_CTRL_BYTE_MASK_EN
    .req_be(4'hF),
`endif
    .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .busy(busy2),
    .SRAM_DQ(sram_dq2), .SRAM_ADDR(sram_addr2), .SRAM_WE_N(we_n2),
    .SRAM_OE_N(oe_n2), .SRAM_CE_N(ce_n2), .SRAM_UB_N(ub_n2), .SRAM_LB_N(lb_n2)
  );

  // SRAM models: drive on read (OE_N low, WE_N high), store bytes on WE_N low.
  assign sram_dq  = (model_en && !ce_n && !oe_n && we_n) ? mem[sram_addr[9:0]] : 16'hzzzz;
  assign sram_dq2 = (!ce_n2 && !oe_n2 && we_n2) ? mem[sram_addr2[9:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (!ce_n && !we_n) begin
      if (!lb_n) mem[sram_addr[9:0]][7:0]  <= sram_dq[7:0];
      if (!ub_n) mem[sram_addr[9:0]][15:8] <= sram_dq[15:8];
    end
  end

  always @(negedge clk) begin
    if (!we_n && !oe_n) contention++;
    if (!we_n) we_low_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  // One request on the WAIT=0 instance; lat counts edges from the accepting
  // edge (inclusive) to the edge after which rsp_valid is seen.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [17:0] first_addr);
    wait_ready();
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    first_addr = sram_addr;
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    $display("txn %s addr=0x%08h wdata=0x%08h latency=%0d rdata=0x%016h",
             we ? "WR" : "RD", addr, wdata, lat, rsp_rdata);
  endtask

  int          lat;
  int          k;
  int          pulses;
  int          we_before;
  logic [17:0] fa;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] <= 16'h0000;
    mem[8]  <= 16'h1111; mem[9]  <= 16'h2222; mem[10] <= 16'h3333; mem[11] <= 16'h4444;
    mem[12] <= 16'hA0A0; mem[13] <= 16'hB1B1; mem[14] <= 16'hC2C2; mem[15] <= 16'hD3D3;
    mem[2]  <= 16'h1122; mem[3]  <= 16'h3344;
    model_en   = 1'b0;
    rst        = 1'b1;
    req_valid  = 1'b0; req_we  = 1'b0; req_addr  = '0; req_wdata  = '0;
    req_valid2 = 1'b0; req_we2 = 1'b0; req_addr2 = '0; req_wdata2 = '0;
`ifdef SRAM_CTRL_BYTE_MASK_EN
    req_be = 4'hF;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    // Reset state, checked with the SRAM model off so only the DUT drives DQ.
    check_eq("rst_ready", req_ready, 1);
    check_eq("rst_valid", rsp_valid, 0);
    check_eq("rst_we_n", we_n, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ce_n", ce_n, 0);
    check_eq("rst_ub_lb", {ub_n, lb_n}, 0);
    check_eq("rst_rdata", rsp_rdata, 0);
    check_eq("rst_dq_z", (sram_dq === 16'hzzzz), 1);
    model_en = 1'b1;

    // Aligned read line
    do_req(1'b0, 32'h0000_0010, 32'h0, lat, fa);
    check_eq("rd_lat", lat, 5);
    check_eq("rd_addr0", fa, 18'd8);
    check_eq("rd_data", rsp_rdata, 64'h4444_3333_2222_1111);

    // Word write
    do_req(1'b1, 32'h0000_0008, 32'hDEAD_BEEF, lat, fa);
    check_eq("wr_lat", lat, 3);
    check_eq("wr_addr0", fa, 18'd4);
    check_eq("wr_mem4", mem[4], 16'hBEEF);
    check_eq("wr_mem5", mem[5], 16'hDEAD);
    check_eq("wr_keeps_rdata", rsp_rdata, 64'h4444_3333_2222_1111);

    // Unaligned read with high address bits set: line base 12, bits >18 ignored
    do_req(1'b0, 32'hFFF8_001A, 32'h0, lat, fa);
    check_eq("rd2_lat", lat, 5);
    check_eq("rd2_addr0", fa, 18'd12);
    check_eq("rd2_data", rsp_rdata, 64'hD3D3_C2C2_B1B1_A0A0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("idle_addr_hold", sram_addr, 18'd15);
    check_eq("idle_we_oe", {we_n, oe_n}, 2'b10);

    // WAIT=2: each address held 3 cycles, rsp_valid on cycle 13, busy until DONE
    @(negedge clk);
    req_valid2 = 1'b1; req_we2 = 1'b0; req_addr2 = 32'h0000_0010;
    @(posedge clk);
    #1;
    req_valid2 = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      check_eq($sformatf("w2_valid_c%0d", c), rsp_valid2, (c == 13) ? 1 : 0);
      check_eq($sformatf("w2_busy_c%0d", c), busy2, (c == 13) ? 0 : 1);
      if (c <= 12) check_eq($sformatf("w2_addr_c%0d", c), sram_addr2, 8 + (c - 1) / 3);
      if (c < 13) begin
        @(posedge clk);
        #1;
      end
    end
    check_eq("w2_data", rsp_rdata2, 64'h4444_3333_2222_1111);
    $display("txn RD(WAIT=2) addr=0x00000010 rdata=0x%016h", rsp_rdata2);

    // Back-to-back: read, then a write held on req_valid
    wait_ready();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0010;
    @(posedge clk);
    #1;
    req_we = 1'b1; req_addr = 32'h0000_0020; req_wdata = 32'h1234_5678;
    k = 1;
    while (!rsp_valid && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    check_eq("b2b_rd_lat", k, 5);
    check_eq("b2b_done_busy", busy, 0);
    check_eq("b2b_done_ready", req_ready, 0);
    $display("txn RD addr=0x00000010 latency=%0d rdata=0x%016h", k, rsp_rdata);
    @(posedge clk);
    #1;
    check_eq("b2b_idle_ready", req_ready, 1);
    check_eq("b2b_idle_busy", busy, 1);
    @(posedge clk);
    #1;
    check_eq("b2b_wr_started", {we_n, req_ready}, 2'b00);
    req_valid = 1'b0;
    k = 1;
    while (!rsp_valid && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    check_eq("b2b_wr_lat", k, 3);
    check_eq("b2b_mem16", mem[16], 16'h5678);
    check_eq("b2b_mem17", mem[17], 16'h1234);
    check_eq("b2b_contention", contention, 0);
    check_eq("b2b_rdata", rsp_rdata, 64'h4444_3333_2222_1111);
    $display("txn WR addr=0x00000020 wdata=0x12345678 latency=%0d", k);

    // Reset in the middle of a read
    wait_ready();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0010;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #2;
    model_en = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("mrd_ready", req_ready, 1);
    check_eq("mrd_valid", rsp_valid, 0);
    check_eq("mrd_we_n", we_n, 1);
    check_eq("mrd_dq_z", (sram_dq === 16'hzzzz), 1);
    check_eq("mrd_rdata", rsp_rdata, 0);
    @(negedge clk);
    rst = 1'b0;
    model_en = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (rsp_valid) pulses++;
    end
    check_eq("mrd_no_rsp", pulses, 0);
    $display("txn RD addr=0x00000010 aborted by reset");

    // Reset in the middle of a write: WE_N must release without a clock edge
    wait_ready();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0030; req_wdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check_eq("mwr_we_active", we_n, 0);
    #2;
    model_en = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("mwr_we_async", we_n, 1);
    check_eq("mwr_dq_z", (sram_dq === 16'hzzzz), 1);
    @(negedge clk);
    rst = 1'b0;
    model_en = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (rsp_valid) pulses++;
    end
    check_eq("mwr_no_rsp", pulses, 0);
    check_eq("mwr_mem24", mem[24], 16'h0000);
    $display("txn WR addr=0x00000030 aborted by reset");

`ifdef SRAM_CTRL_BYTE_MASK_EN
    // Byte mask: only byte 2 enabled -> low byte of halfword 3
    req_be = 4'b0100;
    do_req(1'b1, 32'h0000_0004, 32'h00AB_0000, lat, fa);
    check_eq("be_lat", lat, 3);
    check_eq("be_mem2", mem[2], 16'h1122);
    check_eq("be_mem3", mem[3], 16'h33AB);
    // Empty mask: write timing, WE_N never asserted
    req_be = 4'b0000;
    we_before = we_low_cnt;
    do_req(1'b1, 32'h0000_0004, 32'hFFFF_FFFF, lat, fa);
    check_eq("be0_lat", lat, 3);
    check_eq("be0_we_low", we_low_cnt - we_before, 0);
    check_eq("be0_mem3", mem[3], 16'h33AB);
    req_be = 4'hF;
`else
    we_before = we_low_cnt;
    do_req(1'b1, 32'h0000_0004, 32'h5566_7788, lat, fa);
    check_eq("wr3_lat", lat, 3);
    check_eq("wr3_we_cycles", we_low_cnt - we_before, 2);
    check_eq("wr3_mem2", mem[2], 16'h7788);
    check_eq("wr3_mem3", mem[3], 16'h5566);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_burst_ctrl.md
SRAM_BURST_CTRL -- requirements
Module: sram_burst_ctrl

Interface
REQ-001 SHALL have parameter BURST, default 4, halfwords per read line (power of two, 2..8).
REQ-002 SHALL have parameter WAIT, default 0, extra SRAM cycles per beat (0..7).
REQ-003 SHALL have parameter SRAM_AW, default 18, SRAM halfword address width; SRAM data width fixed at 16.
REQ-004 SHALL have ports clk input 1 clock; rst input 1 reset, asynchronous, active-high.
REQ-005 SHALL have ports req_valid in 1 request strobe; req_ready out 1 accepting; req_we in 1 1=write, 0=read.
REQ-006 SHALL have ports req_addr in 32 byte address; req_wdata in 32 write word.
REQ-007 SHALL have ports rsp_valid out 1 done pulse; rsp_rdata out 16*BURST read line.
REQ-008 SHALL have ports busy out 1 pipeline freeze (=req_valid & ~rsp_valid & ~accept-possible-this-cycle is NOT used; busy = state!=IDLE or req_valid in IDLE).
REQ-009 SHALL have SRAM ports SRAM_DQ inout 16; SRAM_ADDR out SRAM_AW; SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N out 1.

Function
REQ-010 SHALL implement FSM IDLE, READ, WRITE, DONE; req_ready=1 only in IDLE.
REQ-011 SHALL accept on req_valid&req_ready, registering req_we, req_addr, req_wdata; IDLE->READ or WRITE.
REQ-012 SHALL hold each beat WAIT+1 cycles, counted by a wait counter reset to 0 at each beat start.
REQ-013 READ beat i SHALL drive SRAM_ADDR={addr[SRAM_AW:log2(2*BURST)], i}, WE_N=1, OE_N=0; SRAM_DQ sampled into rsp_rdata[16i+15:16i] on the beat's last cycle.
REQ-014 WRITE SHALL issue 2 beats: beat j drives SRAM_ADDR={addr[SRAM_AW:2], j}, SRAM_DQ=wdata[16j+15:16j], WE_N=0 every beat cycle, OE_N=1.
REQ-015 SRAM_DQ SHALL be Z whenever not in a WRITE beat.
REQ-016 After the last beat FSM SHALL enter DONE for exactly one cycle with rsp_valid=1, then IDLE.
REQ-017 Read latency accept-edge to rsp_valid SHALL be BURST*(WAIT+1)+1 cycles; write 2*(WAIT+1)+1.
REQ-018 rsp_rdata SHALL hold its value until the next read's first sample; writes SHALL not modify it.
REQ-019 Beat index SHALL wrap within the aligned line; address bits above SRAM_AW ignored.
REQ-020 busy SHALL be 1 when state!=IDLE except in DONE; in IDLE busy=req_valid, so a new request can be accepted the cycle after DONE.
REQ-021 CE_N SHALL be 0 always; outside beats SRAM_ADDR SHALL hold last value, WE_N=1, OE_N=0.

Reset
REQ-022 On rst: state IDLE, counters 0, rsp_rdata 0, rsp_valid 0, req_ready 1, WE_N 1, DQ Z.
REQ-023 rst mid-operation SHALL abort immediately (WE_N=1 asynchronously); no rsp_valid for the aborted request.

Configuration
REQ-024 With SRAM_CTRL_BYTE_MASK_EN defined: extra input req_be[3:0]; write beat j drives LB_N=~be[2j], UB_N=~be[2j+1]; reads LB_N=UB_N=0; req_be=0000 completes as write timing with WE_N=1.
REQ-025 Without SRAM_CTRL_BYTE_MASK_EN: no req_be port; UB_N=LB_N=0 always.

Structure
REQ-026 Package sram_ctrl_pkg SHALL hold state enum, SRAM_DW=16, WR_BEATS=2 and clog2-based beat-counter width helper.
REQ-027 Sub-module sram_wait_timer SHALL provide the WAIT+1 cycle beat timer with beat-last flag.

Verification
REQ-028 Reset: assert rst mid-read -> req_ready=1, rsp_valid=0, WE_N=1, DQ=Z, rsp_rdata=0.
REQ-029 Read defaults, addr 0x0000_0010, SRAM model halfwords 0x1111,0x2222,0x3333,0x4444 at 8..11 -> rsp_valid 5 cycles after accept, rsp_rdata=0x4444_3333_2222_1111.
REQ-030 Write addr 0x0000_0008, wdata 0xDEAD_BEEF -> SRAM[4]=0xBEEF, SRAM[5]=0xDEAD, rsp_valid 3 cycles after accept.
REQ-031 WAIT=2, read -> each SRAM_ADDR held 3 cycles, rsp_valid at cycle 13, busy high until DONE.
REQ-032 Back-to-back: read then write with req_valid held -> second accepted cycle after DONE, no DQ contention.
REQ-033 With SRAM_CTRL_BYTE_MASK_EN, be=0100, wdata 0x00AB_0000 -> only SRAM[2j=addr+1] low byte =0xAB, other bytes unchanged.
